// File: rtl/rf_pkg.sv
// Shared regfile write-back types: address/data widths, typedefs and the write-back source enum.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef enum logic {
    WB_EXEC = 1'b0,
    WB_LSU  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, preference flips to the other side after every grant.
//   state   | meaning
//   WB_EXEC | req0 wins the next tie
//   WB_LSU  | req1 wins the next tie
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  wb_src_e pref_q, pref_d;

  // No grants while reset is held, so nothing is acknowledged and then lost.
  always_comb begin
    grant_o = 2'b00;
    if (!rst) begin
      grant_o[0] = valid_i[0] & (~valid_i[1] | (pref_q == WB_EXEC));
      grant_o[1] = valid_i[1] & (~valid_i[0] | (pref_q == WB_LSU));
    end
  end

  always_comb begin
    pref_d = pref_q;
    if (grant_o[0]) begin
      pref_d = WB_LSU;
    end else if (grant_o[1]) begin
      pref_d = WB_EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref_q <= WB_EXEC;
    end else begin
      pref_q <= pref_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port sharing between exec and LSU write-back, with a busy scoreboard for issue stalls.
// Optional RF_WB_BYPASS_EN: forward the in-flight write to source operands instead of stalling on them.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_rd,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_rd,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  issue_valid,
  input  logic                  issue_rd_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  rs1_en,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic                  rs2_en,
  input  logic [ADDR_WIDTH-1:0] rs2,
`ifdef RF_WB_BYPASS_EN
  output logic                  rs1_fwd,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic                  rs2_fwd,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data,
`endif
  output logic                  hazard
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [1:0]            grant;
  wb_src_e               sel_src;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic issue_fire;
  logic rs1_byp, rs2_byp;
  logic rs1_hz, rs2_hz, rd_hz;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i ({req1_valid, req0_valid}),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign sel_src  = grant[1] ? WB_LSU : WB_EXEC;
  assign sel_rd   = (sel_src == WB_LSU) ? req1_rd   : req0_rd;
  assign sel_data = (sel_src == WB_LSU) ? req1_data : req0_data;

  // x0 writes are acknowledged but never reach the port.
  always_comb begin
    rf_wen_d   = (|grant) & (sel_rd != '0);
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (|grant) begin
      rf_rd_d    = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  assign issue_fire = issue_valid & issue_rd_en & ~hazard & (issue_rd != '0);

  // Set after clear: a new producer issued on the landing edge keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_BYPASS_EN
  assign rs1_byp      = rf_wen_q & (rs1 == rf_rd_q) & (rs1 != '0);
  assign rs2_byp      = rf_wen_q & (rs2 == rf_rd_q) & (rs2 != '0);
  assign rs1_fwd      = rs1_byp;
  assign rs2_fwd      = rs2_byp;
  assign rs1_fwd_data = rf_wdata_q;
  assign rs2_fwd_data = rf_wdata_q;
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  // WAW on issue_rd is never bypassed: the in-flight write still has to land first.
  assign rs1_hz = rs1_en & (rs1 != '0) & busy_q[rs1] & ~rs1_byp;
  assign rs2_hz = rs2_en & (rs2 != '0) & busy_q[rs2] & ~rs2_byp;
  assign rd_hz  = issue_rd_en & (issue_rd != '0) & busy_q[issue_rd];

  assign hazard = issue_valid & (rs1_hz | rs2_hz | rd_hz);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table, directed hazard/reset sequences, randomized run against a model.
module tb_rf_wb_arbiter;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        issue_valid, issue_rd_en, rs1_en, rs2_en, hazard;
  logic [4:0]  issue_rd, rs1, rs2;
`ifdef RF_WB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: who wins the next tie, the pending port write, and the set of busy registers.
  bit          m_pref;
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_busy[32];
  bit          lg0, lg1;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
    .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
`ifdef RF_WB_BYPASS_EN
    .rs1_fwd(rs1_fwd), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd(rs2_fwd), .rs2_fwd_data(rs2_fwd_data),
`endif
    .hazard(hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    bit          v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    bit          r0;
    bit          r1;
    bit          wen;
    logic [4:0]  rd;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit src_stall(input bit en, input logic [4:0] a, input bit allow_byp);
    if (!en || a == 5'd0 || !m_busy[a]) return 1'b0;
    if (BYP && allow_byp && m_wen && m_rd == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_hazard();
    return issue_valid && (src_stall(rs1_en, rs1, 1'b1) || src_stall(rs2_en, rs2, 1'b1) ||
                           src_stall(issue_rd_en, issue_rd, 1'b0));
  endfunction

  task automatic model_clear();
    m_pref = 1'b0;
    m_wen  = 1'b0;
    m_rd   = '0;
    m_data = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    lg0 = 1'b0;
    lg1 = 1'b0;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = '0;
    rs1_en = 1'b0; rs1 = '0; rs2_en = 1'b0; rs2 = '0;
  endtask

  // Compare current outputs to the model, then advance the model across one clock edge.
  task automatic step();
    bit g0, g1, hz;
    g0 = req0_valid && (!req1_valid || !m_pref);
    g1 = req1_valid && (!req0_valid || m_pref);
    hz = exp_hazard();
    chk("m_req0_ready", req0_ready, g0);
    chk("m_req1_ready", req1_ready, g1);
    chk("m_hazard", hazard, hz);
    chk("m_rf_wen", rf_wen, m_wen);
    if (m_wen) begin
      chk("m_rf_rd", rf_rd, m_rd);
      chk("m_rf_wdata", rf_wdata, m_data);
    end
`ifdef RF_WB_BYPASS_EN
    chk("m_rs1_fwd", rs1_fwd, m_wen && rs1 == m_rd && rs1 != 5'd0);
    chk("m_rs2_fwd", rs2_fwd, m_wen && rs2 == m_rd && rs2 != 5'd0);
    if (m_wen) chk("m_rs1_fwd_data", rs1_fwd_data, m_data);
`endif
    @(posedge clk);
    if (m_wen) m_busy[m_rd] = 1'b0;
    if (issue_valid && issue_rd_en && !hz && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    m_wen = (g0 && req0_rd != 5'd0) || (g1 && req1_rd != 5'd0);
    if (g0) begin
      m_rd = req0_rd; m_data = req0_data; m_pref = 1'b1;
    end else if (g1) begin
      m_rd = req1_rd; m_data = req1_data; m_pref = 1'b0;
    end
    lg0 = g0;
    lg1 = g1;
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1};
    tbl[2] = '{1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 1'b1, 5'd2, 32'hB2};
    tbl[3] = '{1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd1, 32'hA1};
    tbl[4] = '{1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b1, 5'd2, 32'hB2};
    tbl[5] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11};
    tbl[6] = '{1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h00, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[7] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    tbl[8] = '{1'b0, 5'd0, 32'h00, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[9] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 1'b0, 1'b0, 1'b1, 5'd6, 32'h66};

    // Reset: readys must stay low even with both requesters valid.
    idle();
    model_clear();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    idle();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_rf_rd", rf_rd, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);

    // Vector table: alternation, single requesters, x0 write.
    for (int i = 0; i < 10; i++) begin
      req0_valid = tbl[i].v0; req0_rd = tbl[i].rd0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_rd = tbl[i].rd1; req1_data = tbl[i].d1;
      #1;
      chk($sformatf("tbl%0d_req0_ready", i), req0_ready, tbl[i].r0);
      chk($sformatf("tbl%0d_req1_ready", i), req1_ready, tbl[i].r1);
      chk($sformatf("tbl%0d_rf_wen", i), rf_wen, tbl[i].wen);
      if (tbl[i].wen) begin
        chk($sformatf("tbl%0d_rf_rd", i), rf_rd, tbl[i].rd);
        chk($sformatf("tbl%0d_rf_wdata", i), rf_wdata, tbl[i].wd);
      end
      step();
    end

    // RAW on x5 until the LSU write lands.
    idle();
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd5;
    #1;
    chk("x5_issue_hazard", hazard, 1'b0);
    step();
    issue_rd_en = 1'b0; rs1_en = 1'b1; rs1 = 5'd5;
    #1;
    chk("x5_raw_hazard", hazard, 1'b1);
    step();
    chk("x5_raw_hold", hazard, 1'b1);
    req1_valid = 1'b1; req1_rd = 5'd5; req1_data = 32'h55;
    #1;
    chk("x5_lsu_ready", req1_ready, 1'b1);
    chk("x5_raw_at_grant", hazard, 1'b1);
    step();
    req1_valid = 1'b0;
    #1;
    chk("x5_wen_cycle_wen", rf_wen, 1'b1);
`ifdef RF_WB_BYPASS_EN
    chk("x5_wen_cycle_hazard", hazard, 1'b0);
    chk("x5_rs1_fwd", rs1_fwd, 1'b1);
    chk("x5_rs1_fwd_data", rs1_fwd_data, 32'h55);
`else
    chk("x5_wen_cycle_hazard", hazard, 1'b1);
`endif
    step();
    chk("x5_after_write", hazard, 1'b0);
    rs1 = 5'd0; rs2_en = 1'b1; rs2 = 5'd0; issue_rd_en = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_never_hazard", hazard, 1'b0);
    step();

    // Same-edge clear and set of x7: the new producer keeps it busy.
    idle();
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
    #1;
    chk("x7_req0_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd7;
    #1;
    chk("x7_wen", rf_wen, 1'b1);
    chk("x7_rd", rf_rd, 5'd7);
    chk("x7_issue_no_hazard", hazard, 1'b0);
    step();
    issue_rd_en = 1'b0; rs2_en = 1'b1; rs2 = 5'd7;
    #1;
    chk("x7_set_wins", hazard, 1'b1);
    step();

    // Asynchronous reset mid-cycle with a write in flight and x4 busy.
    idle();
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd4;
    #1;
    step();
    issue_rd_en = 1'b0; rs1_en = 1'b1; rs1 = 5'd4;
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
    #1;
    step();
    req0_rd = 5'd10; req0_data = 32'hAA;
    #1;
    chk("arst_pre_wen", rf_wen, 1'b1);
    chk("arst_pre_hazard", hazard, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wen_drop", rf_wen, 1'b0);
    chk("arst_hazard_drop", hazard, 1'b0);
    chk("arst_ready_low", req0_ready, 1'b0);
    model_clear();
    idle();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    issue_valid = 1'b1; rs1_en = 1'b1; rs1 = 5'd4;
    #1;
    chk("arst_x4_cleared", hazard, 1'b0);
    step();

    // Randomized traffic; requesters hold rd/data until accepted.
    idle();
    lg0 = 1'b0;
    lg1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || lg0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_rd    = 5'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!req1_valid || lg1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_rd    = 5'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd_en = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      rs1_en      = 1'($urandom_range(0, 1));
      rs1         = 5'($urandom_range(0, 7));
      rs2_en      = 1'($urandom_range(0, 1));
      rs2         = 5'($urandom_range(0, 7));
      #1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
